// File: rtl/shift_pkg.sv
// Types and constants shared by the PISO shift transmitter and the SIPO receiver.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bit-count register width able to hold the values 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_rx_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a start-marked bit stream
// and presents them through a 1-entry valid/ready output register.
module shift_rx_deser
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    count;

    logic             take_start;
    logic [WIDTH-1:0] sreg_base;
    logic [WIDTH-1:0] sreg_nxt;
    logic             word_done;
    logic             can_load;
    logic             xfer;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        take_start = sin_valid && sin_start;
        // A start bit begins from a clean register so discarded partial bits never leak in.
        sreg_base  = take_start ? '0 : sreg;
        sreg_nxt   = sreg_base;
        if (MSB_FIRST) begin
            sreg_nxt = {sreg_base[WIDTH-2:0], sin};
        end else begin
            sreg_nxt = {sin, sreg_base[WIDTH-1:1]};
        end
        // WIDTH >= 2, so a start bit can never complete a word by itself.
        word_done = (state == SHIFT) && sin_valid && !sin_start && (count == LAST_CNT);
        xfer      = dout_valid && dout_ready;
        can_load  = !dout_valid || dout_ready;
    end

    assign busy = (state == SHIFT);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (take_start) begin
                        sreg  <= sreg_nxt;
                        count <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sin_valid) begin
                        sreg <= sreg_nxt;
                        if (sin_start) begin
                            frame_err <= 1'b1;
                            count     <= CW'(1);
                        end else if (count == LAST_CNT) begin
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Output register: a completed word may refill it on the same edge as a transfer.
            if (word_done && can_load) begin
                dout       <= sreg_nxt;
                dout_valid <= 1'b1;
            end else if (xfer) begin
                dout_valid <= 1'b0;
            end

            // Setting takes priority over clearing on the same edge.
            if (word_done && !can_load) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_rx_deser.sv
// Directed bench for shift_rx_deser: one MSB-first and one LSB-first instance share the stimulus.
module tb_shift_rx_deser;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       sin_start;
    logic       dout_ready;
    logic       clr_err;

    logic [3:0] dout_m, dout_l;
    logic       dout_valid_m, dout_valid_l;
    logic       busy_m, busy_l;
    logic       frame_err_m, frame_err_l;
    logic       overrun_m, overrun_l;

    int tests_run    = 0;
    int tests_failed = 0;

    shift_rx_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_start  (sin_start),
        .dout       (dout_m),
        .dout_valid (dout_valid_m),
        .dout_ready (dout_ready),
        .busy       (busy_m),
        .frame_err  (frame_err_m),
        .overrun    (overrun_m),
        .clr_err    (clr_err)
    );

    shift_rx_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_start  (sin_start),
        .dout       (dout_l),
        .dout_valid (dout_valid_l),
        .dout_ready (dout_ready),
        .busy       (busy_l),
        .frame_err  (frame_err_l),
        .overrun    (overrun_l),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit for one edge; returns 1 time unit after that edge with sin_valid low.
    task automatic send_bit(input logic b, input logic st);
        sin       = b;
        sin_start = st;
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        send_bit(w[3], 1'b1);
        send_bit(w[2], 1'b0);
        send_bit(w[1], 1'b0);
        send_bit(w[0], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        tests_run++;
        if ({dout_m, dout_valid_m, busy_m, frame_err_m, overrun_m} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: got %b required 00000000",
                     {dout_m, dout_valid_m, busy_m, frame_err_m, overrun_m});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (busy_m !== 1'b0 || busy_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ignore: busy got %b/%b required 0/0", busy_m, busy_l);
        end
    endtask

    task automatic test_msb_first;
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (busy_m !== 1'b1 || dout_valid_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL msb_midword: busy=%b valid=%b required busy=1 valid=0", busy_m, dout_valid_m);
        end
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (dout_valid_m !== 1'b1 || dout_m !== 4'b1011 || busy_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL msb_word: valid=%b dout=%b busy=%b required 1 1011 0",
                     dout_valid_m, dout_m, busy_m);
        end
        idle(1);
        tests_run++;
        if (dout_valid_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL msb_one_cycle: valid got %b required 0", dout_valid_m);
        end
    endtask

    task automatic test_lsb_first;
        send_word(4'b1011);
        tests_run++;
        if (dout_valid_l !== 1'b1 || dout_l !== 4'b1101) begin
            tests_failed++;
            $display("FAIL lsb_word: valid=%b dout=%b required 1 1101", dout_valid_l, dout_l);
        end
        idle(1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (busy_l !== 1'b1 || dout_valid_l !== 1'b0) begin
                tests_failed++;
                $display("FAIL lsb_gap_busy[%0d]: busy=%b valid=%b required 1 0", i, busy_l, dout_valid_l);
            end
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (dout_valid_l !== 1'b1 || dout_l !== 4'b1101) begin
            tests_failed++;
            $display("FAIL lsb_gap_word: valid=%b dout=%b required 1 1101", dout_valid_l, dout_l);
        end
        idle(1);
    endtask

    task automatic test_overrun;
        dout_ready = 1'b0;
        send_word(4'b1010);
        tests_run++;
        if (dout_valid_m !== 1'b1 || dout_m !== 4'b1010 || overrun_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_first: valid=%b dout=%b overrun=%b required 1 1010 0",
                     dout_valid_m, dout_m, overrun_m);
        end
        // Second word back-to-back; clr_err on its last edge must lose to the set.
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        clr_err = 1'b1;
        send_bit(1'b0, 1'b0);
        clr_err = 1'b0;
        tests_run++;
        if (dout_m !== 4'b1010 || overrun_m !== 1'b1 || dout_l !== 4'b0101 || overrun_l !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_set: dout=%b/%b overrun=%b/%b required 1010/0101 1/1",
                     dout_m, dout_l, overrun_m, overrun_l);
        end
        idle(2);
        tests_run++;
        if (overrun_m !== 1'b1 || dout_m !== 4'b1010) begin
            tests_failed++;
            $display("FAIL ovr_sticky: overrun=%b dout=%b required 1 1010", overrun_m, dout_m);
        end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        tests_run++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_clear: overrun=%b/%b required 0/0", overrun_m, overrun_l);
        end
        dout_ready = 1'b1;
        idle(1);
        tests_run++;
        if (dout_valid_m !== 1'b0 || dout_valid_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_drain: valid=%b/%b required 0/0", dout_valid_m, dout_valid_l);
        end
    endtask

    task automatic test_frame_err;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (frame_err_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_quiet: frame_err got %b required 0", frame_err_m);
        end
        send_bit(1'b0, 1'b1);
        tests_run++;
        if (frame_err_m !== 1'b1 || busy_m !== 1'b1 || frame_err_l !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_pulse: frame_err=%b/%b busy=%b required 1/1 1",
                     frame_err_m, frame_err_l, busy_m);
        end
        send_bit(1'b0, 1'b0);
        tests_run++;
        if (frame_err_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_single: frame_err got %b required 0", frame_err_m);
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (dout_valid_m !== 1'b1 || dout_m !== 4'b0011 || dout_l !== 4'b1100) begin
            tests_failed++;
            $display("FAIL ferr_word: valid=%b dout=%b/%b required 1 0011/1100",
                     dout_valid_m, dout_m, dout_l);
        end
        idle(1);
    endtask

    task automatic test_reset_midword;
        dout_ready = 1'b0;
        send_word(4'b1111);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({dout_m, dout_valid_m, busy_m, frame_err_m, overrun_m} !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid: got %b required 00000000",
                     {dout_m, dout_valid_m, busy_m, frame_err_m, overrun_m});
        end
        #2;
        rst        = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        send_word(4'b0101);
        tests_run++;
        if (dout_valid_m !== 1'b1 || dout_m !== 4'b0101 || frame_err_m !== 1'b0 || overrun_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_recover: valid=%b dout=%b ferr=%b overrun=%b required 1 0101 0 0",
                     dout_valid_m, dout_m, frame_err_m, overrun_m);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        dout_ready = 1'b0;
        send_word(4'b1111);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        tests_run++;
        if (dout_m !== 4'b1111 || dout_valid_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_hold: dout=%b valid=%b required 1111 1", dout_m, dout_valid_m);
        end
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (dout_valid_m !== 1'b1 || dout_m !== 4'b0001 || overrun_m !== 1'b0 || dout_l !== 4'b1000) begin
            tests_failed++;
            $display("FAIL b2b_reload: valid=%b dout=%b/%b overrun=%b required 1 0001/1000 0",
                     dout_valid_m, dout_m, dout_l, overrun_m);
        end
        idle(1);
        tests_run++;
        if (dout_valid_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: valid got %b required 0", dout_valid_m);
        end
    endtask

    initial begin
        rst        = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        sin_start  = 1'b0;
        dout_ready = 1'b0;
        clr_err    = 1'b0;

        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_frame_err();
        test_reset_midword();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_rx_deser.md
Name:
shift_rx_deser

Overview:
- Serial-to-parallel receiver for words sent by the team's PISO shift transmitter.
- Takes a qualified serial bit stream with a start-of-word marker and assembles WIDTH-bit words.
- Presents each word on a valid/ready parallel output held in a 1-entry output register.
- Flags framing and overrun errors; sits between a serial link and parallel consumer logic.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- sin  input  1  serial data bit
- sin_valid  input  1  sin carries a bit this cycle
- sin_start  input  1  with sin_valid: this bit is the first bit of a word
- dout  output  WIDTH  received word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- busy  output  1  a word is partially received
- frame_err  output  1  one-cycle pulse: sin_start arrived mid-word
- overrun  output  1  sticky: a completed word was dropped
- clr_err  input  1  clears overrun

Behaviour:
- Reset (rst=0, asynchronous): dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0, shift register=0, bit count=0, state=IDLE.
- States:
  - IDLE: waits for a bit.
  - SHIFT: collecting a word.
- IDLE:
  - sin_valid & sin_start -> shift in sin, count=1, go to SHIFT.
  - sin_valid without sin_start is ignored.
- SHIFT:
  - Each sin_valid cycle shifts in sin and increments count.
  - Cycles with sin_valid=0 hold all state. Gaps of any length are legal; there is no timeout.
- Shift order:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
- Word completion: the edge on which the WIDTH-th bit is accepted.
  - State returns to IDLE on that edge.
  - If dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle, the assembled word loads into dout and dout_valid=1 from the next cycle. Latency is 1 clock from the last bit to dout_valid.
  - Otherwise the word is dropped, dout is unchanged, and overrun is set.
- Back-to-back words: a start bit in the cycle immediately after the last bit is accepted (zero gap).
- Output handshake:
  - A transfer occurs when dout_valid & dout_ready at a clock edge.
  - dout_valid clears after the transfer unless a new word loads on the same edge, in which case it stays 1 with the new dout.
  - dout is stable while dout_valid=1 and dout_ready=0.
- Mid-word start: sin_valid & sin_start in SHIFT:
  - frame_err pulses high for 1 cycle.
  - The partial word is discarded.
  - The bit is taken as bit 1 of a new word (count=1); state stays SHIFT.
- overrun:
  - Stays 1 until clr_err=1 at a clock edge.
  - If a set and clr_err occur on the same edge, the set wins.
- busy = (state == SHIFT).
- Reset asserted mid-word: the partial word is lost and any pending dout is cleared; no error flags are raised.

Decomposition:
- Shared package shift_pkg holds:
  - state typedef {IDLE, SHIFT}
  - default word width constant (4), shared with the PISO transmitter
  - clog2-based count-width helper
- Single module; no sub-module needed. Counter and shift register are inline.

Test Plan:
- WIDTH=4, MSB_FIRST=1: sin=1,0,1,1 with sin_start on the first bit, dout_ready=1 -> dout=4'b1011, dout_valid=1 for exactly 1 cycle, starting the cycle after the 4th bit.
- MSB_FIRST=0, same bit sequence -> dout=4'b1101. Repeat with sin_valid low for 3 cycles between bits 2 and 3 -> same result, busy=1 throughout the gap.
- dout_ready=0; send 1010 then 0110 back-to-back -> dout stays 4'b1010, overrun=1 after the second word. Pulse clr_err -> overrun=0. Raise dout_ready -> one transfer, then dout_valid=0.
- Send 1,1, then sin_start with bit 0, then 0,1,1 -> frame_err pulses once; the next word received is 4'b0011.
- Drive rst=0 after 2 bits of a word, release, then send 0101 -> dout=4'b0101, no frame_err, overrun=0.
- dout_valid=1 holding 4'b1111 while a new word 0001 completes with dout_ready=1 on the same edge -> dout_valid stays 1, dout=4'b0001, overrun=0.
